uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side controller for the UART receiver. It generates the receiver's `sync` sample-enable tick from the system clock and holds the receiver in reset while the port is disabled. It captures each completed byte on the rising edge of the receiver's `recv_finish` flag and buffers received bytes in a small FIFO. The FIFO presents bytes downstream on a valid/ready stream and flags overruns.

## Interface
- `DIV`, default 217: system clocks per `sync` tick. The receiver samples at twice the baud rate, so 217 gives 115200 baud at 50 MHz. Legal range 2..65535.
- `AW`, default 3: FIFO address width. Depth is 2**AW entries (default 8).
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  1  port enable; when low, the receiver is held in reset and ticks stop.
- `sync`  out  1  one-clock sample-enable pulse to the receiver, every `DIV` clocks.
- `rx_rst`  out  1  registered reset to the receiver, equal to `rst | ~en`.
- `rx_data`  in  8  receiver byte output.
- `rx_done`  in  1  receiver `recv_finish` flag. It is level-high for several ticks after each byte.
- `m_data`  out  8  head-of-FIFO byte; valid only while `m_valid` is high.
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  downstream accepts `m_data` this cycle.
- `count`  out  AW+1  current FIFO occupancy, 0..2**AW.
- `overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `clr_ovr`  in  1  clears `overrun`.

## Operation
- **Tick divider**
  - 16-bit counter `div_cnt` counts 0..DIV-1 and wraps to 0.
  - `sync` is registered and is 1 for exactly the clock after `div_cnt == DIV-1`.
  - While `rst` or `~en`: `div_cnt = 0` and `sync = 0`.
- **Receiver reset**: `rx_rst` is registered `rst | ~en`. It therefore lags `en` by one clock.
- **Byte capture**
  - `done_d` is a register holding the previous `rx_done`.
  - `push = rx_done & ~done_d & en & ~rx_rst`.
  - `done_d` is forced to 0 while `rx_rst` is 1.
  - On `push`, `rx_data` is written at `wr_ptr` in the same clock.
- **FIFO**
  - Read and write pointers are AW+1 bits. `count = wr_ptr - rd_ptr`, modulo 2**(AW+1).
  - `m_valid = (count != 0)`.
  - `m_data = mem[rd_ptr[AW-1:0]]`, combinational read of registered storage.
  - `pop = m_valid & m_ready`; on `pop`, `rd_ptr` increments.
- **Boundary cases**
  - Empty and `m_ready` high: no pop; pointers unchanged.
  - Full, `push` without `pop`: byte dropped, `wr_ptr` unchanged, `overrun` set to 1.
  - Full, `push` with `pop` in the same clock: both happen, `count` stays at 2**AW, no overrun.
  - Empty, `push` with `m_ready` high: push only. Pop is impossible because `m_valid` is 0 this cycle.
  - Pointer wrap-around is natural binary modulo 2**(AW+1).
  - `clr_ovr` and an overrun in the same clock: `overrun` = 1 (set wins).
- **Disable mid-operation** (`en` falls)
  - Ticks stop the next clock and the receiver enters reset.
  - A byte partially received is lost.
  - FIFO contents and `overrun` are preserved; downstream may keep draining.
- **`rst` mid-operation**: FIFO is flushed (pointers 0) and all state returns to reset values.

## Timing
- **Reset values**: `sync = 0`, `rx_rst = 1`, `m_valid = 0`, `count = 0`, `overrun = 0`. `m_data` is don't-care.
- **First tick**: first `sync` pulse arrives `DIV` clocks after the first clock with `rst = 0` and `en = 1`. Tick period is then exactly `DIV` clocks.
- **Capture latency**: if `rx_done` is first sampled high at edge N, the byte is written at edge N. From edge N+1 onward, `m_valid = 1`, `count` is incremented and `m_data` holds the byte (if the FIFO was empty).
- **Handshake**: a pop takes effect at the edge where `m_valid & m_ready`. The next byte, or `m_valid = 0`, appears after that edge. `m_data` stays stable while `m_valid & ~m_ready`.
- **Held `rx_done`**: a high level lasting any number of clocks produces exactly one push.

## Test plan
- **Tick generation**: DIV=4, `en=1` after reset → `sync` high on clocks 4, 8, 12…, each pulse 1 clock wide. Drop `en` → no further `sync`, `rx_rst = 1` one clock later.
- **Single byte**: `rx_data = 8'hA5`, `rx_done` high for 10 clocks, `m_ready = 0` → one push. Next clock `m_valid = 1`, `m_data = A5`, `count = 1`. Assert `m_ready` → `m_valid = 0` next clock.
- **Ordering and wrap**: AW=3, push 0x00..0x0B while popping after every 3rd push → bytes pop in order 0x00..0x0B, including across pointer wrap-around, `overrun = 0`.
- **Overrun**: fill 8 bytes 0x10..0x17, then push 0x18 with `m_ready = 0` → `count = 8`, `overrun = 1`, pops yield 0x10..0x17 and never 0x18. Pulse `clr_ovr` → `overrun = 0`.
- **Full with push and pop**: FIFO full with 0x20..0x27; push 0x28 with `m_ready = 1` in the same clock → `count` stays 8, `overrun = 0`, final pop order 0x21..0x28.
- **Reset mid-stream**: 5 bytes queued, assert `rst` for one clock → next clock `count = 0`, `m_valid = 0`, `sync = 0`, `rx_rst = 1`. After release, the first `sync` pulse arrives after `DIV` clocks.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sync tick divider, receiver reset, byte capture FIFO with valid/ready output and overrun flag
module uart_rx_ctrl #(
  parameter int DIV = 217,
  parameter int AW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          sync,
  output logic          rx_rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          clr_ovr
);
  logic [15:0] div_cnt_q, div_cnt_d;
  logic        sync_q, sync_d;
  logic        rx_rst_q, rx_rst_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem [2**AW];
  logic        wrap, push, pop, full, wr;
  always_comb begin
    wrap      = div_cnt_q == 16'(DIV - 1);
    div_cnt_d = (~en | wrap) ? '0 : div_cnt_q + 16'd1;
    sync_d    = en & wrap;
    rx_rst_d  = ~en;
    done_d    = rx_rst_q ? 1'b0 : rx_done;
    push      = rx_done & ~done_q & en & ~rx_rst_q;
    count     = wr_ptr_q - rd_ptr_q;
    full      = count[AW];
    m_valid   = count != '0;
    pop       = m_valid & m_ready;
    // a full FIFO only accepts a byte when the head leaves in the same clock
    wr        = push & (~full | pop);
    wr_ptr_d  = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovr_d     = (push & full & ~pop) | (ovr_q & ~clr_ovr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      sync_q    <= 1'b0;
      rx_rst_q  <= 1'b1;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sync_q    <= sync_d;
      rx_rst_q  <= rx_rst_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q[AW-1:0]] <= rx_data;
  end
  assign sync    = sync_q;
  assign rx_rst  = rx_rst_q;
  assign overrun = ovr_q;
  assign m_data  = mem[rd_ptr_q[AW-1:0]];
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and random stimulus, negedge monitor checking against a queue-based reference model
module tb_uart_rx_ctrl;
  localparam int DIV = 4;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1, en = 0, rx_done = 0, m_ready = 0, clr_ovr = 0;
  logic [7:0] rx_data = 0;
  logic sync, rx_rst, m_valid, overrun;
  logic [7:0] m_data;
  logic [AW:0] count;
  int total = 0, bad = 0;
  logic [7:0] exp_q[$];
  logic ovr_m = 0, prev_m = 0, exp_sync = 0, exp_rx_rst = 1;
  logic pop_m, push_m, set_m;
  int run = 0;

  uart_rx_ctrl #(.DIV(DIV), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .rx_rst(rx_rst),
    .rx_data(rx_data), .rx_done(rx_done), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .count(count), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endfunction

  always @(negedge clk) begin
    chk("sync", 32'(sync), 32'(exp_sync));
    chk("rx_rst", 32'(rx_rst), 32'(exp_rx_rst));
    chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("overrun", 32'(overrun), 32'(ovr_m));
    if (exp_q.size() != 0) chk("m_data", 32'(m_data), 32'(exp_q[0]));
    if (rst) begin
      exp_q.delete();
      ovr_m = 0;
      prev_m = 0;
      run = 0;
      exp_sync = 0;
      exp_rx_rst = 1;
    end else begin
      pop_m = exp_q.size() != 0 && m_ready;
      push_m = rx_done && !prev_m && en && !exp_rx_rst;
      set_m = push_m && exp_q.size() == DEPTH && !pop_m;
      if (pop_m) void'(exp_q.pop_front());
      if (push_m && !set_m) exp_q.push_back(rx_data);
      ovr_m = set_m || (ovr_m && !clr_ovr);
      prev_m = exp_rx_rst ? 1'b0 : rx_done;
      run = en ? run + 1 : 0;
      exp_sync = run > 0 && run % DIV == 0;
      exp_rx_rst = !en;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b, int hold);
    rx_data = b;
    rx_done = 1;
    tick(hold);
    rx_done = 0;
    tick(2);
  endtask

  task automatic drain();
    m_ready = 1;
    tick(DEPTH + 2);
    m_ready = 0;
  endtask

  initial begin
    tick(3);
    rst = 0;
    en = 1;
    tick(14);
    en = 0;
    tick(3);
    en = 1;
    tick(3);
    send(8'hA5, 10);
    tick(2);
    m_ready = 1;
    tick(2);
    m_ready = 0;
    for (int i = 0; i < 12; i++) begin
      send(8'(i), 1 + int'($urandom_range(0, 2)));
      if (i % 3 == 2) begin
        m_ready = 1;
        tick(1);
        m_ready = 0;
      end
    end
    drain();
    for (int i = 0; i < 9; i++) send(8'(8'h10 + i), 2);
    tick(1);
    drain();
    clr_ovr = 1;
    tick(1);
    clr_ovr = 0;
    tick(1);
    for (int i = 0; i < 8; i++) send(8'(8'h20 + i), 1);
    rx_data = 8'h28;
    rx_done = 1;
    m_ready = 1;
    tick(1);
    m_ready = 0;
    tick(5);
    rx_done = 0;
    tick(2);
    drain();
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i), 1);
    rst = 1;
    tick(1);
    rst = 0;
    tick(12);
    for (int i = 0; i < 400; i++) begin
      m_ready = $urandom_range(0, 3) == 0;
      clr_ovr = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 2) == 0) rx_done = ~rx_done;
      rx_data = 8'($urandom);
      if ($urandom_range(0, 39) == 0) en = ~en;
      tick(1);
    end
    en = 1;
    rx_done = 0;
    clr_ovr = 0;
    tick(3);
    drain();
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
